// File: rtl/latch_write_scheduler_pkg.sv
// Shared types and timing defaults for the latch write scheduler.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_OPEN_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // Wide enough to hold the longest phase length minus one, plus a spare bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/latch_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/latch_write_scheduler.sv
// Shares one latch bank between N writers; sequences data/enable through
// setup, open and hold phases so D is stable around the transparency window.
//
//   state | meaning
//   IDLE  | sample req, arbitrate, capture winner data
//   SETUP | lat_d driven, enable closed
//   OPEN  | enable low, latches transparent
//   HOLD  | enable closed, lat_d still held; done on last cycle
module latch_write_scheduler
    import latch_sched_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   lat_d,
    output logic           lat_en_n
);

    localparam int CW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    localparam int PW = $clog2(N);

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [PW-1:0] ptr_q, ptr_n;
    logic [PW-1:0] idx_q, idx_n;
    logic [N-1:0]  gnt_n, done_n;
    logic [W-1:0]  lat_d_n;
    logic          busy_n, lat_en_n_n;

    logic [N-1:0]  win_oh;
    logic [PW-1:0] win_idx;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            idx_q    <= '0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            lat_d    <= '0;
            lat_en_n <= 1'b1;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            ptr_q    <= ptr_n;
            idx_q    <= idx_n;
            gnt      <= gnt_n;
            done     <= done_n;
            busy     <= busy_n;
            lat_d    <= lat_d_n;
            lat_en_n <= lat_en_n_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        gnt_n   = gnt;
        lat_d_n = lat_d;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_n = SETUP;
                    cnt_n   = CW'(SETUP_CYC - 1);
                    idx_n   = win_idx;
                    gnt_n   = win_oh;
                    lat_d_n = wdata[int'(win_idx)*W +: W];
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_n = OPEN;
                    cnt_n   = CW'(OPEN_CYC - 1);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_n = HOLD;
                    cnt_n   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    gnt_n   = '0;
                    ptr_n   = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        // Outputs are registered, so derive them from the state being entered.
        done_n     = (state_n == HOLD && cnt_n == '0) ? gnt_n : '0;
        busy_n     = (state_n != IDLE);
        lat_en_n_n = (state_n != OPEN);
    end

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Self-checking bench for latch_write_scheduler (N=4, W=8, 1/2/1 timing).
module tb_latch_write_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt, done;
    logic           busy;
    logic [W-1:0]   lat_d;
    logic           lat_en_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] wdata;
        logic [N-1:0]   exp_gnt;
        logic [W-1:0]   exp_d;
    } vec_t;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    latch_write_scheduler #(
        .N(N), .W(W), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .lat_d    (lat_d),
        .lat_en_n (lat_en_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one transaction from IDLE and check every cycle of its shape.
    task automatic run_txn(input vec_t v, input bit drop_early);
        exp_t e;
        logic [N-1:0] exp_done;
        logic         exp_en;
        req   = v.req;
        wdata = v.wdata;
        sb.push_back('{g: v.exp_gnt, d: v.exp_d});
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_en   = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            exp_done = (k == 3) ? v.exp_gnt : '0;
            check("gnt", 32'(gnt), 32'(v.exp_gnt));
            check("lat_d", 32'(lat_d), 32'(v.exp_d));
            check("busy", 32'(busy), 32'd1);
            check("lat_en_n", 32'(lat_en_n), 32'(exp_en));
            check("done", 32'(done), 32'(exp_done));
            if (done != '0) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_done_gnt", 32'(done), 32'(e.g));
                    check("sb_lat_d", 32'(lat_d), 32'(e.d));
                end
            end
            if (k == 1) begin
                wdata = {$urandom(), $urandom()} >> 32;
                wdata[15:8] = 8'h3C;
                if (drop_early) req = '0;
            end
        end
        tick();
        check("end_gnt", 32'(gnt), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
        check("end_lat_en_n", 32'(lat_en_n), 32'd1);
        req = '0;
    endtask

    initial begin
        logic [N-1:0] order[5];
        logic [N-1:0] prev;
        int gcount, last, waited;

        vecs[0] = '{4'b0010, 32'h4433A511, 4'b0010, 8'hA5};
        vecs[1] = '{4'b1111, 32'h8C7B6A59, 4'b0100, 8'h7B};
        vecs[2] = '{4'b0011, 32'h01020304, 4'b0001, 8'h04};
        vecs[3] = '{4'b0011, 32'hF0E1D2C3, 4'b0010, 8'hD2};
        vecs[4] = '{4'b1001, 32'h5A6B7C8D, 4'b1000, 8'h5A};
        vecs[5] = '{4'b1000, 32'hFF000000, 4'b1000, 8'hFF};
        vecs[6] = '{4'b0101, 32'h12345678, 4'b0001, 8'h78};
        vecs[7] = '{4'b0100, 32'h9ABCDEF0, 4'b0100, 8'hBC};
        vecs[8] = '{4'b1010, 32'h0F1E2D3C, 4'b1000, 8'h0F};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst   = 1'b1;
        req   = 4'($urandom());
        wdata = 32'($urandom());
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_lat_en_n", 32'(lat_en_n), 32'd1);
            check("rst_lat_d", 32'(lat_d), 32'd0);
            req = 4'($urandom());
        end
        rst = 1'b0;
        req = '0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], 1'b0);

        // Continuous requests from everyone: strict rotation, period 5.
        req    = '1;
        prev   = '0;
        gcount = 0;
        last   = 0;
        for (int c = 0; c < 40 && gcount < 5; c++) begin
            tick();
            if (gnt != '0 && prev == '0) begin
                check("rr_order", 32'(gnt), 32'(order[gcount]));
                if (gcount > 0) check("rr_period", 32'(c - last), 32'd5);
                last = c;
                gcount++;
                if (gcount == 5) req = '0;
            end
            prev = gnt;
        end
        check("rr_count", 32'(gcount), 32'd5);
        waited = 0;
        while (busy && waited < 10) begin
            tick();
            waited++;
        end
        check("rr_drain", 32'(busy), 32'd0);

        // Pointer now 1: data changes and req drop mid-OPEN must not matter.
        run_txn('{4'b0010, 32'h0000A500, 4'b0010, 8'hA5}, 1'b1);

        // Abort in OPEN by reset; pointer must come back to 0.
        req   = 4'b0001;
        wdata = 32'h000000C7;
        tick();
        check("abort_gnt", 32'(gnt), 32'b0001);
        tick();
        check("abort_open", 32'(lat_en_n), 32'd0);
        rst = 1'b1;
        req = '0;
        tick();
        check("abort_lat_en_n", 32'(lat_en_n), 32'd1);
        check("abort_gnt0", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        // Requesters 0 and 2: a stale pointer of 2 would pick 0100.
        req   = 4'b0101;
        wdata = 32'h00550011;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        check("post_rst_lat_d", 32'(lat_d), 32'h11);
        req    = '0;
        waited = 0;
        while (busy && waited < 10) begin
            tick();
            waited++;
        end
        check("post_rst_drain", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
